// File: rtl/cache_flush_walker_if.sv
// Line-operation port between the flush walker and the bank pipeline.
interface cache_flush_walker_if #(
    parameter int SET_W = 6,
    parameter int WAY_W = 2
) ();
    logic             op_valid;
    logic             op_ready;
    logic [SET_W-1:0] op_set;
    logic [WAY_W-1:0] op_way;
    logic             op_init;
    logic             op_done;

    modport master (
        output op_valid, op_set, op_way, op_init,
        input  op_ready, op_done
    );

    modport slave (
        input  op_valid, op_set, op_way, op_init,
        output op_ready, op_done
    );
endinterface

// File: rtl/cache_flush_walker.sv
// Per-bank flush sequencer: walks every set/way, issues one line op per line under a
// credit limit, and pulses flush_end once a flush sweep has fully retired.
module cache_flush_walker #(
    parameter int NUM_SETS        = 64,
    parameter int NUM_WAYS        = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic flush_begin,
    output logic flush_end,
    output logic busy,
    cache_flush_walker_if.master op
);
    typedef enum logic [1:0] {INIT, IDLE, WALK, DRAIN} state_t;
    typedef enum logic {MODE_INIT, MODE_FLUSH} mode_t;

    state_t           state;
    mode_t            mode;
    logic [SET_W-1:0] set_cnt;
    logic [WAY_W-1:0] way_cnt;
    logic [CNT_W-1:0] outstanding;
    logic             pend_flush;

    logic issuing;
    logic fire;
    logic retire;
    logic last_way;
    logic last_set;
    logic drain_done;

    assign issuing    = (state == INIT) || (state == WALK);
    assign fire       = op.op_valid && op.op_ready;
    assign retire     = op.op_done && (outstanding != '0);
    assign last_way   = (way_cnt == WAY_W'(NUM_WAYS - 1));
    assign last_set   = (set_cnt == SET_W'(NUM_SETS - 1));
    // The last credit may return in the very cycle the drain is evaluated.
    assign drain_done = (outstanding == '0) || ((outstanding == CNT_W'(1)) && op.op_done);

    assign op.op_valid = issuing && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign op.op_set   = set_cnt;
    assign op.op_way   = way_cnt;
    assign op.op_init  = (mode == MODE_INIT);

    assign busy      = (state != IDLE);
    assign flush_end = (state == DRAIN) && drain_done && (mode == MODE_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT;
            mode        <= MODE_INIT;
            set_cnt     <= '0;
            way_cnt     <= '0;
            outstanding <= '0;
            pend_flush  <= 1'b0;
        end else begin
            if (fire && !retire) begin
                outstanding <= outstanding + 1'b1;
            end else if (retire && !fire) begin
                outstanding <= outstanding - 1'b1;
            end

            if (fire) begin
                if (last_way) begin
                    way_cnt <= '0;
                    if (last_set) begin
                        set_cnt <= '0;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end else begin
                    way_cnt <= way_cnt + 1'b1;
                end
            end

            case (state)
                INIT, WALK: begin
                    if (flush_begin) begin
                        pend_flush <= 1'b1;
                    end
                    if (fire && last_way && last_set) begin
                        state <= DRAIN;
                    end
                end
                IDLE: begin
                    if (flush_begin) begin
                        state <= WALK;
                        mode  <= MODE_FLUSH;
                    end
                end
                DRAIN: begin
                    // A request arriving on the exit cycle folds into the pending sweep.
                    if (drain_done) begin
                        if (pend_flush || flush_begin) begin
                            pend_flush <= 1'b0;
                            state      <= WALK;
                            mode       <= MODE_FLUSH;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush_begin) begin
                        pend_flush <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    a_no_retire_underflow: assert property (
        @(posedge clk) disable iff (reset) op.op_done |-> (outstanding != '0)
    );
endmodule
